// File: rtl/cipher_round_ctrl_if.sv
// Avalon-MM slave bundle for the cipher round controller.
// Master drives the command side; slave answers with data and stall.
interface cipher_round_ctrl_if;
   logic        address;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address,
      output write,
      output read,
      output writedata,
      input  readdata,
      input  waitrequest
   );

   modport slave (
      input  address,
      input  write,
      input  read,
      input  writedata,
      output readdata,
      output waitrequest
   );
endinterface

// File: rtl/cipher_round_ctrl.sv
// Bus front-end and round sequencer for the iterative 128-bit cipher.
// Loads text/key words, runs KEY/SUB/MIX per round, serves readback.
module cipher_round_ctrl #(
   parameter int ROUNDS  = 12,
   parameter int NIBBLES = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   cipher_round_ctrl_if.slave  bus,
   output logic                dp_we,
   output logic [2:0]          dp_widx,
   output logic [31:0]         dp_wdata,
   output logic                dp_mode,
   output logic                dp_keystep,
   output logic                dp_sub_en,
   output logic [3:0]          dp_nib,
   output logic                dp_mix,
   output logic [3:0]          dp_round,
   output logic [6:0]          dp_rcon,
   output logic [1:0]          dp_ridx,
   input  logic [31:0]         dp_rdata,
   output logic                done_irq
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KEY,
      S_SUB,
      S_MIX,
      S_DONE
   } state_t;

   localparam logic [3:0] R_LAST = 4'(ROUNDS - 1);
   localparam logic [3:0] N_LAST = 4'(NIBBLES - 1);
   localparam logic [3:0] C_FULL = 4'd8;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_round;
   logic [1:0]  r_ptr;
   logic        r_ovf;
   logic        r_err;
   logic        r_mode;
   logic        r_we;
   logic [2:0]  r_widx;
   logic [31:0] r_wdata;
   logic        r_keystep;
   logic        r_sub;
   logic [3:0]  r_nib;
   logic        r_mix;
   logic [6:0]  r_rcon;
   logic        r_done;

   logic        w_busy;
   logic        w_dwr;
   logic        w_cwr;
   logic        w_drd;
   logic        w_srd;
   logic        w_start;
   logic        w_abort;
   logic [31:0] w_status;
   logic [31:0] w_rdata;

   // Decrypt walks the constant table backwards.
   function automatic logic [6:0] f_rcon(
      input logic [3:0] rnd,
      input logic       enc
   );
      logic [3:0] idx;
      logic [6:0] rc;
      idx = enc ? rnd : (R_LAST - rnd);
      rc  = 7'h00;
      case (idx)
         4'd0:    rc = 7'h5A;
         4'd1:    rc = 7'h34;
         4'd2:    rc = 7'h73;
         4'd3:    rc = 7'h66;
         4'd4:    rc = 7'h57;
         4'd5:    rc = 7'h35;
         4'd6:    rc = 7'h71;
         4'd7:    rc = 7'h62;
         4'd8:    rc = 7'h5F;
         4'd9:    rc = 7'h25;
         4'd10:   rc = 7'h51;
         4'd11:   rc = 7'h22;
         default: rc = 7'h00;
      endcase
      return rc;
   endfunction

   assign w_busy  = (r_state == S_KEY) ||
                    (r_state == S_SUB) ||
                    (r_state == S_MIX);
   assign w_dwr   = bus.write && !bus.address;
   assign w_cwr   = bus.write &&  bus.address;
   assign w_drd   = bus.read && !bus.write && !bus.address;
   assign w_srd   = bus.read && !bus.write &&  bus.address;
   assign w_start = w_cwr && bus.writedata[0];
   assign w_abort = w_cwr && bus.writedata[2];

   assign w_status = {20'h0, r_cnt, r_round,
                      r_err, r_ovf, r_done, w_busy};

   // Only data-port traffic is held off while a round is in flight.
   assign bus.waitrequest = w_busy && !bus.address &&
                            (bus.read || bus.write);

   always_comb begin
      w_rdata = 32'h0;
      if (w_srd) begin
         w_rdata = w_status;
      end else if (w_drd && (r_state == S_DONE)) begin
         w_rdata = dp_rdata;
      end
   end

   assign bus.readdata = w_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_round   <= 4'd0;
         r_ptr     <= 2'd0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
         r_mode    <= 1'b0;
         r_we      <= 1'b0;
         r_widx    <= 3'd0;
         r_wdata   <= 32'h0;
         r_keystep <= 1'b0;
         r_sub     <= 1'b0;
         r_nib     <= 4'd0;
         r_mix     <= 1'b0;
         r_rcon    <= 7'h00;
         r_done    <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_round   <= 4'd0;
            r_ptr     <= 2'd0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
            r_keystep <= 1'b0;
            r_sub     <= 1'b0;
            r_nib     <= 4'd0;
            r_mix     <= 1'b0;
            r_rcon    <= 7'h00;
            r_done    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_LOAD: begin
                  if (w_dwr) begin
                     if (r_cnt == C_FULL) begin
                        r_ovf <= 1'b1;
                     end else begin
                        r_we    <= 1'b1;
                        r_widx  <= r_cnt[2:0];
                        r_wdata <= bus.writedata;
                        r_cnt   <= r_cnt + 4'd1;
                        r_state <= S_LOAD;
                     end
                  end else if (w_start) begin
                     if ((r_state == S_LOAD) &&
                         (r_cnt == C_FULL)) begin
                        r_mode    <= bus.writedata[1];
                        r_round   <= 4'd0;
                        r_keystep <= 1'b1;
                        r_rcon    <= f_rcon(4'd0,
                                            bus.writedata[1]);
                        r_state   <= S_KEY;
                     end else if (r_cnt < C_FULL) begin
                        r_err <= 1'b1;
                     end
                  end
               end
               S_KEY: begin
                  r_keystep <= 1'b0;
                  r_sub     <= 1'b1;
                  r_nib     <= 4'd0;
                  r_state   <= S_SUB;
               end
               S_SUB: begin
                  if (r_nib == N_LAST) begin
                     r_sub   <= 1'b0;
                     r_nib   <= 4'd0;
                     r_mix   <= 1'b1;
                     r_state <= S_MIX;
                  end else begin
                     r_nib <= r_nib + 4'd1;
                  end
               end
               S_MIX: begin
                  r_mix <= 1'b0;
                  if (r_round == R_LAST) begin
                     r_rcon  <= 7'h00;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_round   <= r_round + 4'd1;
                     r_keystep <= 1'b1;
                     r_rcon    <= f_rcon(r_round + 4'd1,
                                         r_mode);
                     r_state   <= S_KEY;
                  end
               end
               S_DONE: begin
                  if (w_drd) begin
                     r_ptr <= r_ptr + 2'd1;
                     if (r_ptr == 2'd3) begin
                        r_cnt   <= 4'd0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign dp_we      = r_we;
   assign dp_widx    = r_widx;
   assign dp_wdata   = r_wdata;
   assign dp_mode    = r_mode;
   assign dp_keystep = r_keystep;
   assign dp_sub_en  = r_sub;
   assign dp_nib     = r_nib;
   assign dp_mix     = r_mix;
   assign dp_round   = r_round;
   assign dp_rcon    = r_rcon;
   assign dp_ridx    = r_ptr;
   assign done_irq   = r_done;

endmodule
